// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed NUM_DIGITS x 7-segment display driver.
//               Scans double-buffered 4-bit digit values onto a shared
//               active-low segment bus with active-low per-digit anodes.
//               New values loaded via 'load' are committed only at a frame
//               boundary, so a frame is never torn.
// Ports       : clk        - system clock
//               rst_n      - synchronous active-low reset
//               digits_in  - 4*NUM_DIGITS digit values, [3:0] = digit 0
//               dp_in      - per-digit decimal point request (1 = on)
//               load       - 1-cycle strobe capturing digits_in/dp_in
//               enable     - 1 = scan, 0 = display dark (state held)
//               seg_n      - segments {a,b,c,d,e,f,g}, active-low
//               dp_n       - decimal point, active-low
//               an_n       - digit enables, active-low
//               frame_done - 1-cycle pulse when the last slot ends
// Options     : define LEADING_ZERO_BLANK_EN to blank leading zero digits
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_EN       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(CLK_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        index;
  logic [4*NUM_DIGITS-1:0] pending_digits;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic                    pending_valid;
  logic [4*NUM_DIGITS-1:0] active_digits;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic       terminal;
  logic       wrap;
  logic       slot_blank;
  logic       digit_blank;
  logic [3:0] cur_digit;
  logic       cur_dp;

  // Active-low {a..g} decode; codes 10-15 are letters only when HEX_EN=1.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b1100000;
      4'd12:   s = 7'b0110001;
      4'd13:   s = 7'b1000010;
      4'd14:   s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (HEX_EN == 0 && v > 4'd9) begin
      s = SEG_OFF;
    end
    return s;
  endfunction

  always_comb begin
    terminal  = (prescaler == LAST_PS);
    wrap      = enable && terminal && (index == LAST_IDX);
    cur_digit = active_digits[{index, 2'b00} +: 4];
    cur_dp    = active_dp[index];
  end

  // Anti-ghost window at the start of each slot; absent when BLANK_CYCLES=0.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign slot_blank = 1'b0;
    end else begin : g_blank
      assign slot_blank = (prescaler < PS_W'(BLANK_CYCLES));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero with
  // no decimal point requested. Digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  seen;
  always_comb begin
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen       = seen | (active_digits[4*i +: 4] != 4'd0) | active_dp[i];
      lz_mask[i] = ~seen;
    end
  end
  assign digit_blank = lz_mask[index];
`else
  assign digit_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler      <= '0;
      index          <= '0;
      pending_digits <= '0;
      pending_dp     <= '0;
      pending_valid  <= 1'b0;
      active_digits  <= '0;
      active_dp      <= '0;
      seg_n          <= SEG_OFF;
      dp_n           <= 1'b1;
      an_n           <= '1;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= wrap;

      if (enable) begin
        prescaler <= terminal ? '0 : prescaler + 1'b1;
        if (terminal) begin
          index <= (index == LAST_IDX) ? '0 : index + 1'b1;
        end
        seg_n <= (slot_blank || digit_blank) ? SEG_OFF : decode(cur_digit);
        dp_n  <= digit_blank ? 1'b1 : ~cur_dp;
        an_n  <= slot_blank ? '1 : ~(NUM_DIGITS'(1) << index);
      end else begin
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
        an_n  <= '1;
      end

      // Commit at the frame wrap; a load on that same edge bypasses pending.
      if (wrap) begin
        if (load) begin
          active_digits <= digits_in;
          active_dp     <= dp_in;
        end else if (pending_valid) begin
          active_digits <= pending_digits;
          active_dp     <= pending_dp;
        end
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_digits <= digits_in;
        pending_dp     <= dp_in;
        pending_valid  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Scoreboard bench for seven_seg_scan_driver. Two instances
//               (HEX_EN=0 and HEX_EN=1) share stimulus. A reference model
//               derives slot/phase from a count of enabled cycles and pushes
//               expected outputs into a queue; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BC = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0] dp_in;
  logic          load;
  logic          enable;

  logic [6:0]    seg_dec, seg_hex;
  logic          dp_dec, dp_hex;
  logic [ND-1:0] an_dec, an_hex;
  logic          fd_dec, fd_hex;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_EN(0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .seg_n(seg_dec), .dp_n(dp_dec), .an_n(an_dec), .frame_done(fd_dec));

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .seg_n(seg_hex), .dp_n(dp_hex), .an_n(an_hex), .frame_done(fd_hex));

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    seg0;
    logic [6:0]    seg1;
    logic          dp;
    logic          fd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int            n_en;
  logic [4*ND-1:0] m_act;
  logic [ND-1:0] m_actdp;
  logic [4*ND-1:0] m_pend;
  logic [ND-1:0] m_penddp;
  bit            m_pv;

  function automatic logic [6:0] ref_seg(int hex, int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;
      default: begin
        if (hex == 0) return 7'h7F;
        case (v)
          10: return 7'b0001000; 11: return 7'b1100000; 12: return 7'b0110001;
          13: return 7'b1000010; 14: return 7'b0110000; default: return 7'b0111000;
        endcase
      end
    endcase
  endfunction

  function automatic bit lz_blank(int s);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b0;
    for (int j = s; j < ND; j++) begin
      if (((m_act >> (4*j)) & 16'hF) != 0 || m_actdp[j]) return 1'b0;
    end
    return 1'b1;
`else
    return (s < 0);
`endif
  endfunction

  // Reference model: slot and phase come straight from the enabled-cycle count.
  initial begin
    exp_t e;
    int slot, ph, d;
    bit lit, bl, fend;
    n_en = 0; m_act = '0; m_actdp = '0; m_pend = '0; m_penddp = '0; m_pv = 0;
    forever begin
      @(posedge clk);
      e.an = '1; e.seg0 = 7'h7F; e.seg1 = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
      fend = 1'b0;
      if (!rst_n) begin
        n_en = 0; m_act = '0; m_actdp = '0; m_pend = '0; m_penddp = '0; m_pv = 0;
      end else begin
        if (enable) begin
          slot = (n_en / CD) % ND;
          ph   = n_en % CD;
          d    = int'((m_act >> (4*slot)) & 16'hF);
          bl   = lz_blank(slot);
          lit  = (ph >= BC);
          e.an   = lit ? ~(ND'(1) << slot) : '1;
          e.seg0 = (lit && !bl) ? ref_seg(0, d) : 7'h7F;
          e.seg1 = (lit && !bl) ? ref_seg(1, d) : 7'h7F;
          e.dp   = bl ? 1'b1 : ~m_actdp[slot];
          fend   = (slot == ND - 1) && (ph == CD - 1);
          e.fd   = fend;
          n_en++;
        end
        if (fend) begin
          if (load) begin
            m_act = digits_in; m_actdp = dp_in;
          end else if (m_pv) begin
            m_act = m_pend; m_actdp = m_penddp;
          end
          m_pv = 0;
        end else if (load) begin
          m_pend = digits_in; m_penddp = dp_in; m_pv = 1;
        end
      end
      q.push_back(e);
    end
  end

  task automatic chk(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Monitor: compares the registered outputs half a cycle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an_n_dec",  int'(an_dec),  int'(e.an));
        chk("an_n_hex",  int'(an_hex),  int'(e.an));
        chk("seg_n_dec", int'(seg_dec), int'(e.seg0));
        chk("seg_n_hex", int'(seg_hex), int'(e.seg1));
        chk("dp_n_dec",  int'(dp_dec),  int'(e.dp));
        chk("dp_n_hex",  int'(dp_hex),  int'(e.dp));
        chk("frame_done_dec", int'(fd_dec), int'(e.fd));
        chk("frame_done_hex", int'(fd_hex), int'(e.fd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (fd_dec) seen = 1;
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; digits_in = '0; dp_in = '0; load = 1'b0; enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; enable = 1'b1;
    repeat (40) tick();

    // Mid-frame load: must not appear until the next frame boundary.
    repeat (5) tick();
    digits_in = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    repeat (40) tick();

    // Hex codes with decimal points on digits 0 and 2.
    digits_in = 16'hFA98; dp_in = 4'b0101; load = 1'b1; tick(); load = 1'b0;
    repeat (40) tick();

    // Two loads within a frame, then a third coincident with the wrap edge.
    wait_fd();
    #1;
    repeat (3) tick();
    digits_in = 16'h1111; dp_in = 4'b0000; load = 1'b1; tick(); load = 1'b0;
    repeat (4) tick();
    digits_in = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    repeat (6) tick();
    digits_in = 16'h3333; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();

    // Pause mid-slot and resume.
    repeat (6) tick();
    enable = 1'b0; repeat (10) tick(); enable = 1'b1;
    repeat (20) tick();

    // Leading-zero patterns (also meaningful when that option is off).
    digits_in = 16'h0050; dp_in = 4'b0000; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();
    dp_in = 4'b1000; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();

    // Reset mid-frame discards everything.
    repeat (7) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (20) tick();

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      enable    = ($urandom_range(0, 15) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    load = 1'b0; rst_n = 1'b1; enable = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
